// File: rtl/mips_pkg.sv
// Shared types for the multicycle MIPS memory responder: FSM encoding,
// request error classes and the acceptance-time error classifier.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_BOTH     = 2'd1,
        ERR_MISALIGN = 2'd2,
        ERR_RANGE    = 2'd3
    } err_e;

    // Priority order: both-high, then misaligned, then out-of-range.
    function automatic err_e classify(input logic rd, input logic wr,
                                      input logic [31:0] addr, input int aw);
        if (rd && wr)
            return ERR_BOTH;
        if (addr[1:0] != 2'b00)
            return ERR_MISALIGN;
        if ((addr >> (aw + 2)) != 32'd0)
            return ERR_RANGE;
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Core-to-memory request/response bundle; master is the core control path,
// slave is the memory responder.
interface mem_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  memRead;
    logic                  memWrite;
    logic [31:0]           addr;
    logic [DATA_WIDTH-1:0] writeData;
    logic [DATA_WIDTH-1:0] readData;
    logic                  memReady;
    logic                  memError;

    modport master (
        output memRead, memWrite, addr, writeData,
        input  readData, memReady, memError
    );

    modport slave (
        input  memRead, memWrite, addr, writeData,
        output readData, memReady, memError
    );
endinterface

// File: rtl/mem_array.sv
// Single-port synchronous word RAM with write enable and registered read.
// Contents are deliberately not reset.
module mem_array #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        if (re)
            rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one word request, waits LATENCY cycles, then
// pulses memReady/memError with registered readData.
module mem_responder
    import mips_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 2
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    wr_q, wr_d;
    err_e                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    ready_q, ready_d;
    logic                    error_q, error_d;

    logic                    ram_we;
    logic                    ram_re;
    logic [DATA_WIDTH-1:0]   ram_rdata;

    mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        error_d = 1'b0;
        ram_we  = 1'b0;
        ram_re  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.memRead || bus.memWrite) begin
                    addr_d  = bus.addr[ADDR_WIDTH+1:2];
                    wdata_d = bus.writeData;
                    wr_d    = bus.memWrite;
                    err_d   = classify(bus.memRead, bus.memWrite, bus.addr, ADDR_WIDTH);
                    cnt_d   = CNT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    // Prefetch so the synchronous RAM output is valid during RESP.
                    ram_re  = (err_q == ERR_NONE) && !wr_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                ready_d = 1'b1;
                error_d = (err_q != ERR_NONE);
                case (err_q)
                    ERR_NONE: begin
                        if (wr_q)
                            ram_we = !reset;
                        else
                            rdata_d = ram_rdata;
                    end
                    ERR_BOTH: ;
                    default:  rdata_d = '0;
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            err_q   <= ERR_NONE;
            rdata_q <= '0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            error_q <= error_d;
        end
    end

    assign bus.readData = rdata_q;
    assign bus.memReady = ready_q;
    assign bus.memError = error_q;
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: LATENCY=2 and LATENCY=1 instances
// checked against a behavioural word-memory model.
module tb_mem_responder;
    localparam int LAT0 = 2;
    localparam int LAT1 = 1;
    localparam int AW   = 8;
    localparam int DEPTH = 2**AW;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;

    exp_t q0[$];
    exp_t q1[$];

    logic [31:0] mem_m [2][DEPTH];
    logic [31:0] rd_m  [2];

    mem_responder_if #(.DATA_WIDTH(32)) bus0 ();
    mem_responder_if #(.DATA_WIDTH(32)) bus1 ();

    mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .LATENCY(LAT0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .LATENCY(LAT1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int lat_of(input int sel);
        return (sel == 0) ? LAT0 : LAT1;
    endfunction

    // Reference behaviour: plain word memory plus the last-read register.
    task automatic model(input int sel, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd, output exp_t e);
        logic err;
        logic [31:0] idx;
        idx = a / 4;
        err = (rd && wr) || (a % 4 != 0) || (a >= 4 * DEPTH);
        if (rd && wr) begin
        end else if (err) begin
            rd_m[sel] = 32'd0;
        end else if (wr) begin
            mem_m[sel][idx] = wd;
        end else begin
            rd_m[sel] = mem_m[sel][idx];
        end
        e.rdata = rd_m[sel];
        e.err   = err;
        e.acc   = 0;
    endtask

    task automatic push(input int sel, input exp_t e);
        if (sel == 0) q0.push_back(e);
        else          q1.push_back(e);
    endtask

    task automatic set_req(input int sel, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] wd);
        if (sel == 0) begin
            bus0.memRead = rd; bus0.memWrite = wr; bus0.addr = a; bus0.writeData = wd;
        end else begin
            bus1.memRead = rd; bus1.memWrite = wr; bus1.addr = a; bus1.writeData = wd;
        end
    endtask

    task automatic wait_ready(input int sel, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((sel == 0 && bus0.memReady) || (sel == 1 && bus1.memReady)) begin
                ok = 1'b1;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL ready_timeout dut%0d actual=no_memReady required=memReady", sel);
    endtask

    task automatic issue(input int sel, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        bit   ok;
        @(negedge clk);
        set_req(sel, rd, wr, a, wd);
        model(sel, rd, wr, a, wd, e);
        e.acc = cyc + 1;
        push(sel, e);
        @(negedge clk);
        set_req(sel, 1'b0, 1'b0, a, wd);
        wait_ready(sel, ok);
    endtask

    // memRead held high: each IDLE cycle after a response starts a new read.
    task automatic b2b(input int sel, input logic [31:0] a, input int n);
        exp_t e;
        bit   ok;
        int   prev;
        prev = 0;
        @(negedge clk);
        set_req(sel, 1'b1, 1'b0, a, 32'd0);
        model(sel, 1'b1, 1'b0, a, 32'd0, e);
        e.acc = cyc + 1;
        push(sel, e);
        for (int k = 0; k < n; k++) begin
            wait_ready(sel, ok);
            if (!ok) break;
            if (k > 0)
                chk("b2b_gap", 32'(cyc - prev), 32'(lat_of(sel) + 2));
            prev = cyc;
            if (k < n - 1) begin
                model(sel, 1'b1, 1'b0, a, 32'd0, e);
                e.acc = cyc + 1;
                push(sel, e);
            end else begin
                set_req(sel, 1'b0, 1'b0, a, 32'd0);
            end
        end
        set_req(sel, 1'b0, 1'b0, a, 32'd0);
    endtask

    task automatic mon(input int sel, input logic rdy, input logic err, input logic [31:0] rdata);
        exp_t e;
        if (err && !rdy) begin
            checks++;
            errors++;
            $display("FAIL lone_error dut%0d actual=memError_without_memReady required=none", sel);
        end
        if (!rdy) return;
        if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready dut%0d actual=memReady required=idle", sel);
            return;
        end
        e = (sel == 0) ? q0.pop_front() : q1.pop_front();
        chk(sel == 0 ? "rdata0" : "rdata1", rdata, e.rdata);
        chk(sel == 0 ? "err0" : "err1", {31'd0, err}, {31'd0, e.err});
        chk(sel == 0 ? "lat0" : "lat1", 32'(cyc - e.acc), 32'(lat_of(sel) + 1));
    endtask

    always @(negedge clk) if (!reset) mon(0, bus0.memReady, bus0.memError, bus0.readData);
    always @(negedge clk) if (!reset) mon(1, bus1.memReady, bus1.memError, bus1.readData);

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ready"}, {31'd0, bus0.memReady}, 32'd0);
        chk({tag, "_error"}, {31'd0, bus0.memError}, 32'd0);
        chk({tag, "_rdata"}, bus0.readData, 32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 6) return 32'($urandom_range(0, DEPTH - 1)) << 2;
        if (r == 7) return (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
        if (r == 8) return ($urandom & ~32'h3) | 32'h400;
        return ($urandom_range(0, 1) == 0) ? 32'h3FC : 32'h400;
    endfunction

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rd_m[0] = 32'd0;
        rd_m[1] = 32'd0;
        reset = 1'b1;
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset0");
        chk("reset1_ready", {31'd0, bus1.memReady}, 32'd0);
        chk("reset1_rdata", bus1.readData, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < DEPTH; i++)
            issue(0, 1'b0, 1'b1, 32'(i * 4), $urandom | 32'h1);

        issue(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        issue(0, 1'b1, 1'b0, 32'h10, 32'd0);
        issue(0, 1'b1, 1'b0, 32'h06, 32'd0);
        issue(0, 1'b1, 1'b0, 32'h04, 32'd0);
        issue(0, 1'b1, 1'b1, 32'h20, 32'h55AA55AA);
        issue(0, 1'b1, 1'b0, 32'h20, 32'd0);
        issue(0, 1'b0, 1'b1, 32'h3FC, 32'h12345678);
        issue(0, 1'b1, 1'b0, 32'h3FC, 32'd0);
        issue(0, 1'b0, 1'b1, 32'h400, 32'hBAD0BAD0);
        issue(0, 1'b1, 1'b0, 32'h0, 32'd0);
        issue(0, 1'b0, 1'b1, 32'h0000_0402, 32'h0BADF00D);
        issue(0, 1'b1, 1'b0, 32'h8, 32'd0);

        // Reset while the write sits in WAIT: the store must be lost.
        issue(0, 1'b1, 1'b0, 32'h40, 32'd0);
        @(negedge clk);
        set_req(0, 1'b0, 1'b1, 32'h40, 32'hCAFEF00D);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 32'h40, 32'd0);
        reset = 1'b1;
        #1;
        chk_idle_outputs("rst_wait");
        rd_m[0] = 32'd0;
        rd_m[1] = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        issue(0, 1'b1, 1'b0, 32'h40, 32'd0);

        // Reset during RESP: the write edge never arrives.
        @(negedge clk);
        set_req(0, 1'b0, 1'b1, 32'h44, 32'hFEEDFACE);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 32'h44, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk_idle_outputs("rst_resp");
        rd_m[0] = 32'd0;
        rd_m[1] = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        issue(0, 1'b1, 1'b0, 32'h44, 32'd0);

        b2b(0, 32'h0, 3);

        for (int i = 0; i < 80; i++) begin
            int t;
            t = $urandom_range(0, 19);
            issue(0, t < 9 || t >= 18, t >= 9, rand_addr(), $urandom);
        end

        issue(1, 1'b0, 1'b1, 32'h8, 32'hA5A55A5A);
        issue(1, 1'b1, 1'b0, 32'h8, 32'd0);
        issue(1, 1'b1, 1'b0, 32'h9, 32'd0);
        issue(1, 1'b0, 1'b1, 32'h0, 32'h00C0FFEE);
        b2b(1, 32'h8, 3);
        b2b(1, 32'h0, 2);

        repeat (6) @(negedge clk);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
